char_fifo_fwft: RTL

- Synchronous first-word-fall-through character FIFO in the UART transmit path.
- Producers (MIPS debug/response logic) push bytes on the write port.
- The transmit controller pops them through the empty/dout/rd_en interface.
- Single clock domain (clk_tx). Adds occupancy count and sticky error flags for debug.

---
 rtl/char_fifo_fwft.sv | 89 ++++++++
 1 files changed

// File: rtl/char_fifo_fwft.sv
// First-word-fall-through character FIFO for the UART transmit path.
// Occupancy counter drives full/empty; sticky overflow/underflow for debug.
module char_fifo_fwft #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_tx,
   input  logic                  rst_clk_tx,
   input  logic [DATA_WIDTH-1:0] char_fifo_din,
   input  logic                  char_fifo_wr_en,
   output logic                  char_fifo_full,
   output logic                  char_fifo_empty,
   output logic [DATA_WIDTH-1:0] char_fifo_dout,
   input  logic                  char_fifo_rd_en,
   output logic [ADDR_WIDTH:0]   char_fifo_count,
   input  logic                  flag_clr,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  ovf_evt;
   logic                  udf_evt;

   assign char_fifo_full  = (count == DEPTH_CNT);
   assign char_fifo_empty = (count == '0);
   assign char_fifo_count = count;
   assign char_fifo_dout  = mem[rd_ptr];

   // A pop frees the slot in the same cycle, so a push at full is legal then.
   assign push_ok = char_fifo_wr_en & (~char_fifo_full | char_fifo_rd_en);
   assign pop_ok  = char_fifo_rd_en & ~char_fifo_empty;
   assign ovf_evt = char_fifo_wr_en & char_fifo_full & ~char_fifo_rd_en;
   assign udf_evt = char_fifo_rd_en & char_fifo_empty;

   always_ff @(posedge clk_tx) begin
      if (push_ok && !rst_clk_tx) begin
         mem[wr_ptr] <= char_fifo_din;
      end
   end

   always_ff @(posedge clk_tx) begin
      if (rst_clk_tx) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // New events take priority over a coincident clear.
   always_ff @(posedge clk_tx) begin
      if (rst_clk_tx) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt) begin
            overflow <= 1'b1;
         end else if (flag_clr) begin
            overflow <= 1'b0;
         end
         if (udf_evt) begin
            underflow <= 1'b1;
         end else if (flag_clr) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule
